// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline definitions: register/icode constants and scoreboard entry type.
package y86_pkg;

  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef struct packed {
    logic       vld;
    logic [3:0] dstE;
    logic [3:0] dstM;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '{vld: 1'b0, dstE: RNONE, dstM: RNONE};

endpackage

// File: rtl/fwd_mux_port.sv
// Per-port forwarding priority search over the in-flight scoreboard entries,
// producing the forwarded operand and a load-use hazard flag.
module fwd_mux_port
  import y86_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned DEPTH    = 3,
  parameter logic [DEPTH-1:0] VALM_RDY = 3'b110
) (
  input  logic [3:0]              tag,
  input  logic [XLEN-1:0]         rval,
  input  logic [XLEN-1:0]         valP,
  input  logic                    useValP,
  input  sb_entry_t [DEPTH-1:0]   entries,
  input  logic [XLEN*DEPTH-1:0]   s_valE,
  input  logic [XLEN*DEPTH-1:0]   s_valM,
  output logic [XLEN-1:0]         val,
  output logic                    hazard
);

  logic found;

  // Youngest stage first; within one entry dstM is checked before dstE so a
  // not-yet-ready load result stalls rather than forwarding a stale valE.
  always_comb begin
    val    = rval;
    hazard = 1'b0;
    found  = 1'b0;
    if (useValP) begin
      val   = valP;
      found = 1'b1;
    end
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (!found && entries[k].vld && tag != RNONE) begin
        if (tag == entries[k].dstM) begin
          found = 1'b1;
          if (VALM_RDY[k]) val = s_valM[k*XLEN +: XLEN];
          else             hazard = 1'b1;
        end else if (tag == entries[k].dstE) begin
          found = 1'b1;
          val   = s_valE[k*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand forwarding and load-use interlock between decode and execute, with an
// internal destination-tag shift register and a saturating stall counter.
module fwd_scoreboard
  import y86_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NSRC     = 2,
  parameter int unsigned DEPTH    = 3,
  parameter logic [DEPTH-1:0] VALM_RDY = 3'b110,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            D_icode,
  input  logic [XLEN-1:0]       D_valP,
  input  logic [4*NSRC-1:0]     d_src,
  input  logic [XLEN*NSRC-1:0]  d_rval,
  input  logic [3:0]            d_dstE,
  input  logic [3:0]            d_dstM,
  input  logic                  flush,
  input  logic [XLEN*DEPTH-1:0] s_valE,
  input  logic [XLEN*DEPTH-1:0] s_valM,
  output logic [XLEN*NSRC-1:0]  d_val,
  output logic                  d_stall,
  output logic [CNT_W-1:0]      stall_cnt
);

  sb_entry_t [DEPTH-1:0] entries;
  logic [NSRC-1:0]       hazard;
  logic                  isCtl;

  assign isCtl = (D_icode == IJXX) || (D_icode == ICALL);

  for (genvar p = 0; p < int'(NSRC); p++) begin : g_port
    fwd_mux_port #(
      .XLEN     (XLEN),
      .DEPTH    (DEPTH),
      .VALM_RDY (VALM_RDY)
    ) u_port (
      .tag     (d_src[4*p +: 4]),
      .rval    (d_rval[XLEN*p +: XLEN]),
      .valP    (D_valP),
      .useValP ((p == 0) && isCtl),
      .entries (entries),
      .s_valE  (s_valE),
      .s_valM  (s_valM),
      .val     (d_val[XLEN*p +: XLEN]),
      .hazard  (hazard[p])
    );
  end

  assign d_stall = |hazard;

  // Stage tag shift register; a stalled or squashed decode enters E as a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) entries[k] <= SB_BUBBLE;
    end else begin
      for (int k = int'(DEPTH) - 1; k > 0; k--) entries[k] <= entries[k-1];
      if (flush || d_stall) entries[0] <= SB_BUBBLE;
      else                  entries[0] <= '{vld: 1'b1, dstE: d_dstE, dstM: d_dstM};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             stall_cnt <= '0;
    else if (d_stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard; a second instance with a 2-bit counter
// exercises counter saturation on the same stimulus.
module tb_fwd_scoreboard;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NSRC  = 2;
  localparam int unsigned DEPTH = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [3:0]            D_icode;
  logic [XLEN-1:0]       D_valP;
  logic [4*NSRC-1:0]     d_src;
  logic [XLEN*NSRC-1:0]  d_rval;
  logic [3:0]            d_dstE, d_dstM;
  logic                  flush;
  logic [XLEN*DEPTH-1:0] s_valE, s_valM;
  logic [XLEN*NSRC-1:0]  d_val, d_val2;
  logic                  d_stall, d_stall2;
  logic [15:0]           stall_cnt;
  logic [1:0]            stall_cnt2;

  int nTests = 0;
  int nFail  = 0;

  fwd_scoreboard dut (
    .clk(clk), .rst(rst), .D_icode(D_icode), .D_valP(D_valP), .d_src(d_src),
    .d_rval(d_rval), .d_dstE(d_dstE), .d_dstM(d_dstM), .flush(flush),
    .s_valE(s_valE), .s_valM(s_valM), .d_val(d_val), .d_stall(d_stall),
    .stall_cnt(stall_cnt)
  );

  fwd_scoreboard #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .D_icode(D_icode), .D_valP(D_valP), .d_src(d_src),
    .d_rval(d_rval), .d_dstE(d_dstE), .d_dstM(d_dstM), .flush(flush),
    .s_valE(s_valE), .s_valM(s_valM), .d_val(d_val2), .d_stall(d_stall2),
    .stall_cnt(stall_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    D_icode = 4'h0;
    D_valP  = 64'h0;
    d_src   = 8'h32;
    d_rval  = {64'h33, 64'h22};
    d_dstE  = 4'hF;
    d_dstM  = 4'hF;
    flush   = 1'b0;
    s_valE  = {64'hE2, 64'hE1, 64'hE0};
    s_valM  = {64'hD2, 64'hD1, 64'hD0};
    #2;
    chk("rst_val0", d_val[63:0], 64'h22);
    chk("rst_val1", d_val[127:64], 64'h33);
    chk("rst_stall", 64'(d_stall), 64'h0);
    chk("rst_cnt", 64'(stall_cnt), 64'h0);
    D_icode = 4'h8; D_valP = 64'h40; #1;
    chk("rst_call_valP", d_val[63:0], 64'h40);
    D_icode = 4'h0;
    @(negedge clk);
    rst = 1'b0;

    // E forward beats M forward
    d_src = 8'hFF; d_dstE = 4'h2;
    tick(); tick();
    d_dstE = 4'hF;
    s_valE = {64'hE2, 64'hBB, 64'hAA};
    d_src  = 8'hF2; #1;
    chk("e_beats_m", d_val[63:0], 64'hAA);
    chk("e_beats_m_stall", 64'(d_stall), 64'h0);

    // dstE == dstM: stall while in E, dstM wins once in M
    d_src = 8'hFF; d_dstE = 4'h4; d_dstM = 4'h4;
    tick();
    d_src = 8'hF4; #1;
    chk("dupdst_in_e_stall", 64'(d_stall), 64'h1);
    d_src = 8'hFF; d_dstE = 4'hF; d_dstM = 4'hF;
    tick();
    s_valM = {64'hD2, 64'h11, 64'hD0};
    s_valE = {64'hE2, 64'h99, 64'hE0};
    d_src  = 8'hF4; #1;
    chk("dupdst_m_valM", d_val[63:0], 64'h11);
    chk("dupdst_m_stall", 64'(d_stall), 64'h0);

    // Load-use
    d_src = 8'hFF; D_icode = 4'h5; d_dstM = 4'h5; d_dstE = 4'hF;
    tick();
    D_icode = 4'h0; d_dstM = 4'hF; d_dstE = 4'h6; d_src = 8'h5F; #1;
    chk("lu_stall", 64'(d_stall), 64'h1);
    chk("lu_cnt_before", 64'(stall_cnt), 64'h0);
    tick();
    chk("lu_stall_clear", 64'(d_stall), 64'h0);
    chk("lu_val1", d_val[127:64], 64'h11);
    chk("lu_cnt", 64'(stall_cnt), 64'h1);
    d_src = 8'h56; #1;
    chk("lu_bubble", d_val[63:0], 64'h22);
    tick();
    d_src = 8'hF6; #1;
    chk("lu_reissue", d_val[63:0], 64'hE0);

    // Call uses D_valP on port 0 only; RNONE source reads the register file
    d_src = 8'hFF; d_dstE = 4'h4;
    tick();
    D_icode = 4'h8; D_valP = 64'h100; d_src = 8'hF4; #1;
    chk("call_valP", d_val[63:0], 64'h100);
    chk("call_rnone_val1", d_val[127:64], 64'h33);
    d_dstE = 4'hF;
    tick();
    chk("rnone_vs_F_entry", d_val[127:64], 64'h33);
    d_src = 8'h4F; #1;
    chk("call_port1_fwd", d_val[127:64], 64'h99);
    D_icode = 4'h0;

    // Flush squashes the decode destination
    d_src = 8'hFF; d_dstE = 4'h3; flush = 1'b1;
    tick();
    flush = 1'b0; d_dstE = 4'hF; d_src = 8'hF3; #1;
    chk("flush_no_fwd", d_val[63:0], 64'h22);
    d_src = 8'hFF; d_dstE = 4'h3;
    tick();
    d_dstE = 4'hF; d_src = 8'hF3; #1;
    chk("noflush_fwd", d_val[63:0], 64'hE0);

    // Jump on port 0 masks the hazard; back-to-back load stalls saturate dut2
    d_src = 8'hFF; d_dstM = 4'h7;
    tick();
    d_dstM = 4'hF; D_icode = 4'h7; D_valP = 64'h200; d_src = 8'hF7; #1;
    chk("jxx_mask_stall", 64'(d_stall), 64'h0);
    chk("jxx_valP", d_val[63:0], 64'h200);
    D_icode = 4'h0; #1;
    chk("stall_1", 64'(d_stall), 64'h1);
    tick();
    for (int i = 0; i < 2; i++) begin
      d_src = 8'hFF; d_dstM = 4'h7;
      tick();
      d_dstM = 4'hF; d_src = 8'hF7; #1;
      chk("stall_loop", 64'(d_stall), 64'h1);
      tick();
    end
    chk("cnt_after_loop", 64'(stall_cnt), 64'h4);
    chk("cnt_saturated", 64'(stall_cnt2), 64'h3);

    // Async reset mid-stall clears stall and counter immediately
    d_src = 8'hFF; d_dstM = 4'h7;
    tick();
    d_dstM = 4'hF; d_src = 8'hF7; #1;
    chk("pre_rst_stall", 64'(d_stall), 64'h1);
    rst = 1'b1; #1;
    chk("midrst_stall", 64'(d_stall), 64'h0);
    chk("midrst_cnt", 64'(stall_cnt), 64'h0);
    chk("midrst_cnt2", 64'(stall_cnt2), 64'h0);
    chk("midrst_val0", d_val[63:0], 64'h22);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised operand-forwarding and load-use interlock unit for the Y86-64 pipeline, sitting between decode and execute. It supplies NSRC decode operands, choosing among the register-file read data, D_valP and results in flight in up to DEPTH downstream stages. Destination tags for those in-flight instructions come from an internal shift-register scoreboard rather than from stage pipeline registers. It raises a stall when an operand depends on a memory result that is not yet available, inserts the matching bubble itself, and counts stall cycles.

## Interface
Parameters:
- XLEN, 64, data width
- NSRC, 2, decode source ports; port 0 is srcA
- DEPTH, 3, tracked stages after decode; index 0 = E, 1 = M, 2 = W
- VALM_RDY, 3'b110, bit k set means valM exists at stage k
- CNT_W, 16, stall counter width

Ports (all tags are register IDs; 4'hF = RNONE):
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; asynchronous, active-high
- D_icode  in  4  icode in decode
- D_valP  in  XLEN  decode PC increment
- d_src  in  4*NSRC  packed source IDs, port p at [4p+3:4p]
- d_rval  in  XLEN*NSRC  register-file read data per port
- d_dstE, d_dstM  in  4 each  destinations of the decode instruction
- flush  in  1  mispredict/ret squash of the decode instruction
- s_valE  in  XLEN*DEPTH  valE per stage (stage 0 = e_valE)
- s_valM  in  XLEN*DEPTH  valM per stage; ignored where VALM_RDY bit is 0
- d_val  out  XLEN*NSRC  forwarded operands
- d_stall  out  1  hold F/D, bubble E
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- The scoreboard holds DEPTH entries {vld, dstE, dstM}. Entry k describes the instruction currently in stage k.
- Each posedge, entries shift k -> k+1 and entry DEPTH-1 is dropped.
- Entry 0 loads {1, d_dstE, d_dstM} unless d_stall or flush is high; in that case it loads a bubble {0, F, F}.
- Forwarding for port p is priority-ordered and first match wins:
  1. For p == 0 and D_icode in {7 (jXX), 8 (call)}: D_valP.
  2. For k = 0..DEPTH-1, youngest first: if VALM_RDY[k] is set and the tag equals dstM[k], take s_valM[k]; otherwise, if the tag equals dstE[k], take s_valE[k].
  3. Otherwise: d_rval[p].
- A match requires vld[k] and a tag other than F. A source tag of F never matches and yields d_rval.
- Load-use: hazard[p] is true when tag == dstM[k] for some vld entry k with VALM_RDY[k] == 0, and no younger stage matched first.
- d_stall = OR of hazard[p] over all ports, excluding port 0 when step 1 applies.
- While d_stall is high, d_val is don't-care.
- flush has priority over d_stall for the entry-0 load. Flush does not gate d_stall; the hazard unit upstream masks it.
- stall_cnt increments on each posedge with d_stall high and saturates at all-ones.

## Timing
- d_val and d_stall are combinational from the entries and inputs, with zero-cycle latency.
- Scoreboard state and stall_cnt update on posedge clk.
- Reset (async assert): all entries {0, F, F} and stall_cnt = 0. Consequently d_stall = 0 and d_val = d_rval, or D_valP on port 0 for icode 7/8.
- Deassertion takes effect at the next posedge.
- A load-use stall lasts exactly one cycle at DEPTH = 3, VALM_RDY = 3'b110, because the load moves to M, where valM is ready.
- Back-to-back stalls from different loads each count separately.
- When dstE == dstM in one entry, dstM wins if ready; otherwise it stalls.
- Reset mid-stall clears the stall in the same cycle.

## Structure
- The shared package y86_pkg holds:
  - RNONE = 4'hF
  - icode constants: IJXX = 7, ICALL = 8, IMRMOVQ = 5, IPOPQ = 11
  - a typedef sb_entry_t {vld, dstE, dstM}
- One sub-module, fwd_mux_port, is instantiated NSRC times (generate loop). It performs the per-port priority search and emits {val, hazard}.
- The top level holds the entry shift register, the stall OR and the counter.

## Test plan
- Reset: rst = 1, d_src = {4'h3, 4'h2}, d_rval = {0x33, 0x22} -> d_val = {0x33, 0x22}, d_stall = 0, stall_cnt = 0.
- E forward beats M: entry0.dstE = 2 with s_valE[0] = 0xAA, entry1.dstE = 2 with s_valE[1] = 0xBB, d_src[0] = 2 -> d_val[0] = 0xAA.
- M dstM before dstE: entry1 {dstE = 4, dstM = 4}, s_valM[1] = 0x11, s_valE[1] = 0x99, d_src = 4 -> 0x11.
- Load-use:
  - Stimulus: mrmovq with d_dstM = 5 issued, then next decode d_src[1] = 5.
  - Required: d_stall = 1 for one cycle and entry 0 becomes a bubble.
  - Following cycle: d_stall = 0, d_val[1] = s_valM[1], stall_cnt = 1.
- Call/RNONE: D_icode = 8, D_valP = 0x100, entry0.dstE = 4 with d_src[0] = 4 -> d_val[0] = 0x100. Separately, d_src[1] = F while entry0.dstE = F -> d_val[1] = d_rval[1].
- Flush + saturation: flush = 1 with d_dstE = 3 -> next cycle no forwarding from tag 3. Preload stall_cnt to 0xFFFF, then stall -> count stays 0xFFFF.
